muldiv_alu: RTL
===============

MULDIV_ALU -- requirements
Module: muldiv_alu

Interface
REQ-001 Parameter N, default `XLEN, data width in bits; N SHALL be even and >= 8.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 in_valid  input  1  operand/op request.
REQ-005 in_ready  output  1  block accepts a request.
REQ-006 a, b  input  N  operands.
REQ-007 op  input  5  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 EQ, 6 NE, 7 SLT, 8 SLTU, 9 SGE, 10 SGEU, 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU; all other codes illegal.
REQ-008 flush  input  1  abort the operation in flight.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 result  output  N  operation result.
REQ-012 illegal  output  1  qualifies result; op was illegal.

Function
REQ-013 Transfers SHALL occur on valid&&ready at a rising edge; in_ready SHALL be 1 only in state IDLE.
REQ-014 States SHALL be IDLE, BUSY, DONE; accept of op 0-10 or an illegal op SHALL go IDLE->DONE; accept of op 16-23 SHALL go IDLE->BUSY.
REQ-015 Ops 0-10 SHALL present result one cycle after accept; compare ops SHALL return 0 or 1 zero-extended; SLT/SGE SHALL be signed and SLTU/SGEU unsigned.
REQ-016 BUSY SHALL iterate one bit per cycle for exactly N cycles, then go to DONE; mul/div latency SHALL be N+1 cycles from accept to out_valid.
REQ-017 MUL SHALL return the low N bits of the 2N-bit product; MULH/MULHSU/MULHU SHALL return the high N bits with a,b signed/signed, signed/unsigned, and unsigned/unsigned.
REQ-018 DIV/REM SHALL be signed, truncating toward zero, with the remainder taking the sign of the dividend; DIVU/REMU SHALL be unsigned.
REQ-019 Divide by zero SHALL yield quotient all-ones and remainder = a, with the same latency.
REQ-020 Signed overflow (a = most negative, b = -1) SHALL yield quotient = a and remainder 0.
REQ-021 Illegal op SHALL yield result 0 and illegal=1 one cycle after accept; illegal SHALL be 0 for every legal op.
REQ-022 In DONE, out_valid SHALL be 1 and result/illegal SHALL be held stable until out_ready; out_valid&&out_ready SHALL go DONE->IDLE.
REQ-023 After a result is consumed, the next request SHALL be accepted no earlier than the following cycle.
REQ-024 flush in BUSY or DONE SHALL go to IDLE next cycle with out_valid=0 and no result delivered; flush in IDLE SHALL block acceptance that cycle; flush SHALL take priority over every handshake.
REQ-025 Operands SHALL be captured at accept; changes on a/b/op while busy SHALL have no effect.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force state IDLE, out_valid=0, result=0, illegal=0; in_ready SHALL be 1 in the first cycle after release.
REQ-027 Reset asserted mid-operation SHALL discard the operation; no result SHALL appear after release.

Configuration
REQ-028 Macro ALU_MULDIV_EN: when defined, ops 16-23 SHALL behave per REQ-016..020.
REQ-029 When ALU_MULDIV_EN is undefined, ops 16-23 SHALL be illegal per REQ-021, no iterative datapath SHALL be built, and state BUSY SHALL be unreachable.

Verification
REQ-030 N=32, ADD a=7 b=0xFFFFFFFF, out_ready=1 -> out_valid on cycle 1, result 6, illegal 0.
REQ-031 MULH a=0x80000000 b=0x80000000 -> out_valid on cycle 33, result 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 DIV a=-7 b=2 -> result -3; REM -> -1; DIVU a=5 b=0 -> 0xFFFFFFFF; REMU -> 5; DIV a=0x80000000 b=-1 -> 0x80000000; REM -> 0.
REQ-033 SLTU a=1 b=2 with out_ready=0 for 5 cycles -> out_valid and result 1 held, in_ready 0 throughout; a transfer then occurs on the first out_ready=1 cycle.
REQ-034 DIVU accepted, flush on cycle 10 -> IDLE on cycle 11, no out_valid; a new ADD is accepted and completes normally. Repeat with rst_n=0 on cycle 10 -> same.
REQ-035 op=12 -> result 0, illegal 1; build without ALU_MULDIV_EN, op=16 -> illegal 1 after 1 cycle.

Source files
------------

// File: rtl/muldiv_alu.sv
// Single-cycle ALU plus an optional one-bit-per-cycle multiply/divide unit behind a valid/ready handshake.
// Define ALU_MULDIV_EN to build the iterative mul/div datapath; otherwise ops 16-23 are reported illegal.
`ifndef XLEN
`define XLEN 32
`endif

module muldiv_alu #(
    parameter int N = `XLEN
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [4:0]   op,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         illegal
);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_EQ     = 5'd5;
    localparam logic [4:0] OP_NE     = 5'd6;
    localparam logic [4:0] OP_SLT    = 5'd7;
    localparam logic [4:0] OP_SLTU   = 5'd8;
    localparam logic [4:0] OP_SGE    = 5'd9;
    localparam logic [4:0] OP_SGEU   = 5'd10;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] result_q, result_d;
    logic         illegal_q, illegal_d;
    logic [N-1:0] alu_res;
    logic         alu_op;
    logic         accept;

    assign in_ready  = (state_q == IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign illegal   = illegal_q;

    always_comb begin
        alu_res = '0;
        alu_op  = 1'b1;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_EQ:   alu_res = {{(N-1){1'b0}}, a == b};
            OP_NE:   alu_res = {{(N-1){1'b0}}, a != b};
            OP_SLT:  alu_res = {{(N-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: alu_res = {{(N-1){1'b0}}, a < b};
            OP_SGE:  alu_res = {{(N-1){1'b0}}, $signed(a) >= $signed(b)};
            OP_SGEU: alu_res = {{(N-1){1'b0}}, a >= b};
            default: alu_op  = 1'b0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam int         CW        = $clog2(N);

    logic [2:0]     mop_q, mop_d;
    logic [N-1:0]   m_q, m_d;
    logic [2*N-1:0] p_q, p_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d;
    logic [N-1:0]   a_q, a_d;
    logic           bz_q, bz_d;

    logic           md_op, a_sgn, b_sgn, a_neg, b_neg;
    logic [N-1:0]   a_mag, b_mag;
    logic [N:0]     add_sum, sh;
    logic [N+1:0]   diff;
    logic           fit;
    logic [2*N-1:0] p_step, prod;
    logic [N-1:0]   dsel, md_res;

    // Operands are reduced to magnitudes at accept; the sign is re-applied once at the end.
    always_comb begin
        md_op = (op[4:3] == 2'b10);
        a_sgn = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_sgn = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg = a_sgn && a[N-1];
        b_neg = b_sgn && b[N-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // p_q holds {acc, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        add_sum = {1'b0, p_q[2*N-1:N]} + (p_q[0] ? {1'b0, m_q} : '0);
        sh      = {p_q[2*N-1:N], p_q[N-1]};
        diff    = {1'b0, sh} - {2'b00, m_q};
        fit     = !diff[N+1];
        if (mop_q[2]) p_step = {fit ? diff[N-1:0] : sh[N-1:0], p_q[N-2:0], fit};
        else          p_step = {add_sum, p_q[N-1:1]};
        prod = neg_q ? -p_step : p_step;
        dsel = mop_q[1] ? p_step[2*N-1:N] : p_step[N-1:0];
        if (!mop_q[2])  md_res = (mop_q[1:0] == 2'b00) ? prod[N-1:0] : prod[2*N-1:N];
        else if (bz_q)  md_res = mop_q[1] ? a_q : '1;
        else            md_res = neg_q ? -dsel : dsel;
    end
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
`ifdef ALU_MULDIV_EN
        mop_d = mop_q;
        m_d   = m_q;
        p_d   = p_q;
        cnt_d = cnt_q;
        neg_d = neg_q;
        a_d   = a_q;
        bz_d  = bz_q;
`endif
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (alu_op) begin
                            state_d   = DONE;
                            result_d  = alu_res;
                            illegal_d = 1'b0;
                        end
`ifdef ALU_MULDIV_EN
                        else if (md_op) begin
                            state_d   = BUSY;
                            illegal_d = 1'b0;
                            mop_d     = op[2:0];
                            cnt_d     = '0;
                            a_d       = a;
                            bz_d      = (b == '0);
                            if (op[2]) begin
                                m_d   = b_mag;
                                p_d   = {{N{1'b0}}, a_mag};
                                neg_d = op[1] ? a_neg : (a_neg ^ b_neg);
                            end else begin
                                m_d   = a_mag;
                                p_d   = {{N{1'b0}}, b_mag};
                                neg_d = a_neg ^ b_neg;
                            end
                        end
`endif
                        else begin
                            state_d   = DONE;
                            result_d  = '0;
                            illegal_d = 1'b1;
                        end
                    end
                end
                BUSY: begin
`ifdef ALU_MULDIV_EN
                    p_d   = p_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(N-1)) begin
                        state_d  = DONE;
                        result_d = md_res;
                    end
`else
                    state_d = IDLE;
`endif
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
`ifdef ALU_MULDIV_EN
            mop_q <= '0;
            m_q   <= '0;
            p_q   <= '0;
            cnt_q <= '0;
            neg_q <= 1'b0;
            a_q   <= '0;
            bz_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
`ifdef ALU_MULDIV_EN
            mop_q <= mop_d;
            m_q   <= m_d;
            p_q   <= p_d;
            cnt_q <= cnt_d;
            neg_q <= neg_d;
            a_q   <= a_d;
            bz_q  <= bz_d;
`endif
        end
    end

endmodule
